// File: rtl/id_ex_stage.sv
// id_ex_stage
//   ID/EX pipeline register with load-use hazard detection for a 16-register,
//   16-bit, 5-stage pipeline. Captures decoded operands and control from ID
//   and inserts a one-cycle bubble when a load in EX feeds the instruction
//   in ID.
//
// Parameters
//   DATA_W  operand / immediate width
//   REG_W   register specifier width (R0 is hardwired zero)
//   CTRL_W  opaque EX/MEM/WB control bundle width
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   if_id_*               decoded instruction fields presented by ID
//   flush                 taken branch/jump in EX; kill the ID instruction
//   stall                 combinational; hold PC and IF/ID this cycle
//   id_ex_*               registered fields driven into EX / forwarding unit
//   stall_count           (HAZARD_STATS_EN only) saturating stall-cycle count
//   flush_count           (HAZARD_STATS_EN only) saturating flush-cycle count
//
// Optional feature
//   Define HAZARD_STATS_EN to add the stall_count / flush_count outputs.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 4,
  parameter int CTRL_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_id_valid,
  input  logic [REG_W-1:0]         if_id_rs,
  input  logic [REG_W-1:0]         if_id_rt,
  input  logic [REG_W-1:0]         if_id_rd,
  input  logic                     if_id_uses_rt,
  input  logic signed [DATA_W-1:0] if_id_rs_data,
  input  logic signed [DATA_W-1:0] if_id_rt_data,
  input  logic signed [DATA_W-1:0] if_id_imm,
  input  logic                     if_id_regwrite,
  input  logic                     if_id_memread,
  input  logic                     if_id_memwrite,
  input  logic [CTRL_W-1:0]        if_id_ctrl,
  input  logic                     flush,
  output logic                     stall,
  output logic                     id_ex_valid,
  output logic [REG_W-1:0]         id_ex_rs,
  output logic [REG_W-1:0]         id_ex_rt,
  output logic [REG_W-1:0]         id_ex_rd,
  output logic signed [DATA_W-1:0] id_ex_rs_data,
  output logic signed [DATA_W-1:0] id_ex_rt_data,
  output logic signed [DATA_W-1:0] id_ex_imm,
  output logic                     id_ex_regwrite,
  output logic                     id_ex_memread,
  output logic                     id_ex_memwrite,
  output logic [CTRL_W-1:0]        id_ex_ctrl
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]              stall_count,
  output logic [15:0]              flush_count
`endif
);

  logic hazard;
  logic rs_match;
  logic rt_match;
  logic bubble;

  // Load in EX whose destination is read by the valid instruction in ID.
  // R0 is never written, so a load to R0 cannot create a dependency.
  always_comb begin
    rs_match = (id_ex_rd == if_id_rs);
    rt_match = if_id_uses_rt & (id_ex_rd == if_id_rt);
    hazard   = id_ex_memread & (id_ex_rd != '0) & if_id_valid & (rs_match | rt_match);
    stall    = hazard & ~flush;
    bubble   = flush | stall;
  end

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_ex_valid    <= 1'b0;
      id_ex_rs       <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
      id_ex_rs_data  <= '0;
      id_ex_rt_data  <= '0;
      id_ex_imm      <= '0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_ctrl     <= '0;
    end else if (bubble) begin
      // Bubble: R0 specifiers and no side effects, so a stalled bubble can
      // never itself raise a hazard on the re-presented instruction.
      id_ex_valid    <= 1'b0;
      id_ex_rs       <= '0;
      id_ex_rt       <= '0;
      id_ex_rd       <= '0;
      id_ex_rs_data  <= '0;
      id_ex_rt_data  <= '0;
      id_ex_imm      <= '0;
      id_ex_regwrite <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_ctrl     <= '0;
    end else begin
      id_ex_valid    <= if_id_valid;
      id_ex_rs       <= if_id_rs;
      id_ex_rt       <= if_id_rt;
      id_ex_rd       <= if_id_rd;
      id_ex_rs_data  <= if_id_rs_data;
      id_ex_rt_data  <= if_id_rt_data;
      id_ex_imm      <= if_id_imm;
      id_ex_regwrite <= if_id_regwrite & if_id_valid;
      id_ex_memread  <= if_id_memread & if_id_valid;
      id_ex_memwrite <= if_id_memwrite & if_id_valid;
      id_ex_ctrl     <= if_id_ctrl;
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall) stall_count <= sat_inc(stall_count);
      if (flush) flush_count <= sat_inc(flush_count);
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_id_valid;
  logic [3:0]  if_id_rs, if_id_rt, if_id_rd;
  logic        if_id_uses_rt;
  logic signed [15:0] if_id_rs_data, if_id_rt_data, if_id_imm;
  logic        if_id_regwrite, if_id_memread, if_id_memwrite;
  logic [7:0]  if_id_ctrl;
  logic        flush;
  logic        stall;
  logic        id_ex_valid;
  logic [3:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic signed [15:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite;
  logic [7:0]  id_ex_ctrl;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_count, flush_count;
`endif

  id_ex_stage #(.DATA_W(16), .REG_W(4), .CTRL_W(8)) dut (
    .clk(clk), .rst(rst),
    .if_id_valid(if_id_valid), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .if_id_rd(if_id_rd), .if_id_uses_rt(if_id_uses_rt),
    .if_id_rs_data(if_id_rs_data), .if_id_rt_data(if_id_rt_data),
    .if_id_imm(if_id_imm), .if_id_regwrite(if_id_regwrite),
    .if_id_memread(if_id_memread), .if_id_memwrite(if_id_memwrite),
    .if_id_ctrl(if_id_ctrl), .flush(flush), .stall(stall),
    .id_ex_valid(id_ex_valid), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
    .id_ex_rd(id_ex_rd), .id_ex_rs_data(id_ex_rs_data),
    .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memread(id_ex_memread),
    .id_ex_memwrite(id_ex_memwrite), .id_ex_ctrl(id_ex_ctrl)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [3:0]  rs, rt, rd;
    logic [15:0] rs_data, rt_data, imm;
    logic        regwrite, memread, memwrite;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   exp_stalls = 0;
  int   exp_flushes = 0;

  function automatic exp_t observed();
    exp_t o;
    o.valid    = id_ex_valid;
    o.rs       = id_ex_rs;
    o.rt       = id_ex_rt;
    o.rd       = id_ex_rd;
    o.rs_data  = id_ex_rs_data;
    o.rt_data  = id_ex_rt_data;
    o.imm      = id_ex_imm;
    o.regwrite = id_ex_regwrite;
    o.memread  = id_ex_memread;
    o.memwrite = id_ex_memwrite;
    o.ctrl     = id_ex_ctrl;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Present one ID instruction, check stall against the hand-derived value,
  // queue the ID/EX contents the edge should produce, then clock and compare.
  task automatic step(input string tag, input logic v, input logic [3:0] rs,
                      input logic [3:0] rt, input logic [3:0] rd, input logic ur,
                      input logic [15:0] rsd, input logic [15:0] rtd,
                      input logic [15:0] imm, input logic rw, input logic mr,
                      input logic mw, input logic [7:0] ctrl, input logic fl,
                      input logic exp_stall);
    exp_t e;
    if_id_valid = v; if_id_rs = rs; if_id_rt = rt; if_id_rd = rd;
    if_id_uses_rt = ur; if_id_rs_data = rsd; if_id_rt_data = rtd;
    if_id_imm = imm; if_id_regwrite = rw; if_id_memread = mr;
    if_id_memwrite = mw; if_id_ctrl = ctrl; flush = fl;
    #1;
    chk({tag, "_stall"}, {127'd0, stall}, {127'd0, exp_stall});
    if (fl || exp_stall) e = '0;
    else begin
      e.valid = v; e.rs = rs; e.rt = rt; e.rd = rd;
      e.rs_data = rsd; e.rt_data = rtd; e.imm = imm;
      e.regwrite = rw & v; e.memread = mr & v; e.memwrite = mw & v;
      e.ctrl = ctrl;
    end
    exp_q.push_back(e);
    if (exp_stall) exp_stalls++;
    if (fl) exp_flushes++;
    @(posedge clk);
    #1;
    chk({tag, "_idex"}, {56'd0, observed()}, {56'd0, exp_q.pop_front()});
  endtask

  initial begin
    rst = 1'b1;
    if_id_valid = 0; if_id_rs = 0; if_id_rt = 0; if_id_rd = 0; if_id_uses_rt = 0;
    if_id_rs_data = 0; if_id_rt_data = 0; if_id_imm = 0; if_id_regwrite = 0;
    if_id_memread = 0; if_id_memwrite = 0; if_id_ctrl = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_idex", {56'd0, observed()}, 128'd0);
    chk("por_stall", {127'd0, stall}, 128'd0);
    rst = 1'b0;

    step("pass", 1, 4'd1, 4'd2, 4'd3, 1, 16'h1234, 16'h00AA, 16'hFFF0, 1, 0, 0, 8'h5A, 0, 0);

    // Asynchronous reset mid-cycle with nonzero inputs still applied.
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_idex", {56'd0, observed()}, 128'd0);
    chk("rst_mid_stall", {127'd0, stall}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Load-use on rs.
    step("ld5",     1, 4'd1, 4'd0, 4'd5, 0, 16'h0010, 16'h0000, 16'h0004, 1, 1, 0, 8'h01, 0, 0);
    step("use5_s",  1, 4'd5, 4'd2, 4'd7, 1, 16'h0BAD, 16'h0022, 16'h0000, 1, 0, 0, 8'h02, 0, 1);
    step("use5_go", 1, 4'd5, 4'd2, 4'd7, 1, 16'h0BAD, 16'h0022, 16'h0000, 1, 0, 0, 8'h02, 0, 0);
    // rs == rt == load rd: one stall only.
    step("ld8",     1, 4'd2, 4'd0, 4'd8, 0, 16'h0020, 16'h0000, 16'h0008, 1, 1, 0, 8'h03, 0, 0);
    step("use8_s",  1, 4'd8, 4'd8, 4'd9, 1, 16'h0001, 16'h0002, 16'h0000, 1, 0, 0, 8'h04, 0, 1);
    step("use8_go", 1, 4'd8, 4'd8, 4'd9, 1, 16'h0001, 16'h0002, 16'h0000, 1, 0, 0, 8'h04, 0, 0);
    // Load to R0 never stalls.
    step("ld0",     1, 4'd1, 4'd0, 4'd0, 0, 16'h0030, 16'h0000, 16'h000C, 1, 1, 0, 8'h05, 0, 0);
    step("use0",    1, 4'd0, 4'd0, 4'd2, 1, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 8'h06, 0, 0);
    // Immediate form ignores rt.
    step("ld4",     1, 4'd1, 4'd0, 4'd4, 0, 16'h0040, 16'h0000, 16'h0010, 1, 1, 0, 8'h07, 0, 0);
    step("imm4",    1, 4'd1, 4'd4, 4'd3, 0, 16'h0050, 16'h0060, 16'h8000, 1, 0, 0, 8'h08, 0, 0);
    // Back-to-back dependent loads.
    step("ld9",     1, 4'd1, 4'd0, 4'd9, 0, 16'h0070, 16'h0000, 16'h0014, 1, 1, 0, 8'h09, 0, 0);
    step("ldld_s",  1, 4'd9, 4'd0, 4'hA, 0, 16'h0080, 16'h0000, 16'h0018, 1, 1, 0, 8'h0A, 0, 1);
    step("ldld_go", 1, 4'd9, 4'd0, 4'hA, 0, 16'h0080, 16'h0000, 16'h0018, 1, 1, 0, 8'h0A, 0, 0);
    // Flush overrides the hazard.
    step("ld6",     1, 4'd1, 4'd0, 4'd6, 0, 16'h0090, 16'h0000, 16'h001C, 1, 1, 0, 8'h0B, 0, 0);
    step("flush6",  1, 4'd6, 4'd0, 4'd2, 1, 16'h00A0, 16'h00B0, 16'h0000, 1, 0, 0, 8'h0C, 1, 0);
    // Invalid slot: write-side controls gated, so it cannot act as a load.
    step("inval",   0, 4'd1, 4'd0, 4'hB, 0, 16'h00C0, 16'h00D0, 16'h0020, 1, 1, 1, 8'h0D, 0, 0);
    step("after_iv",1, 4'hB, 4'd0, 4'd3, 0, 16'h00E0, 16'h0000, 16'h0000, 1, 0, 0, 8'h0E, 0, 0);
    // Invalid ID instruction never stalls even with a matching rs.
    step("ldC",     1, 4'd1, 4'd0, 4'hC, 0, 16'h00F0, 16'h0000, 16'h0024, 1, 1, 0, 8'h0F, 0, 0);
    step("ivuseC",  0, 4'hC, 4'd0, 4'd3, 0, 16'h0100, 16'h0000, 16'h0000, 1, 0, 0, 8'h10, 0, 0);

`ifdef HAZARD_STATS_EN
    chk("stall_count", {112'd0, stall_count}, 128'(exp_stalls));
    chk("flush_count", {112'd0, flush_count}, 128'(exp_flushes));
`endif

    // Reset asserted while a stall is being signalled.
    step("ldD",     1, 4'd1, 4'd0, 4'hD, 0, 16'h0110, 16'h0000, 16'h0028, 1, 1, 0, 8'h11, 0, 0);
    if_id_valid = 1; if_id_rs = 4'hD; if_id_rt = 4'd0; if_id_rd = 4'd2;
    if_id_uses_rt = 0; if_id_memread = 0; if_id_memwrite = 0; flush = 0;
    #1;
    chk("pre_rst_stall", {127'd0, stall}, 128'd1);
    rst = 1'b1;
    #1;
    chk("rst_stall_idex", {56'd0, observed()}, 128'd0);
    chk("rst_stall_stall", {127'd0, stall}, 128'd0);
`ifdef HAZARD_STATS_EN
    chk("rst_counts", {96'd0, stall_count, flush_count}, 128'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register combined with load-use hazard detection for the 16-register, 16-bit, 5-stage pipeline.
- Captures decoded operands and control from ID each cycle.
- Drives id_ex_rs, id_ex_rt and id_ex_rd into the forwarding unit and EX stage.
- Inserts a one-cycle bubble and stalls PC and IF/ID when a load is followed by a dependent instruction.

Parameters:
- DATA_W, 16, width of register operands and immediate.
- REG_W, 4, register specifier width (16 registers; R0 hardwired zero).
- CTRL_W, 8, width of the opaque EX/MEM/WB control bundle passed through unchanged.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_id_valid  in  1  ID holds a real instruction.
- if_id_rs  in  REG_W  source register A specifier.
- if_id_rt  in  REG_W  source register B specifier.
- if_id_rd  in  REG_W  destination specifier.
- if_id_uses_rt  in  1  instruction reads rt (0 for immediate forms).
- if_id_rs_data  in  DATA_W  register file read A.
- if_id_rt_data  in  DATA_W  register file read B.
- if_id_imm  in  DATA_W  sign-extended immediate.
- if_id_regwrite  in  1  instruction writes rd.
- if_id_memread  in  1  instruction is a load.
- if_id_memwrite  in  1  instruction is a store.
- if_id_ctrl  in  CTRL_W  remaining control bits.
- flush  in  1  branch/jump taken in EX; kill the ID instruction.
- stall  out  1  hold PC and IF/ID this cycle (combinational).
- id_ex_valid  out  1  registered valid.
- id_ex_rs, id_ex_rt, id_ex_rd  out  REG_W  registered specifiers.
- id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  DATA_W  registered operands.
- id_ex_regwrite, id_ex_memread, id_ex_memwrite  out  1  registered control.
- id_ex_ctrl  out  CTRL_W  registered control bundle.

Behaviour:
- Reset (async, rst=1): every id_ex_* output clears to 0. A bubble with R0 specifiers results. stall reads 0 while id_ex_memread=0.
- Hazard (combinational): hazard = id_ex_memread & (id_ex_rd != 0) & if_id_valid & ((id_ex_rd == if_id_rs) | (if_id_uses_rt & (id_ex_rd == if_id_rt))).
- stall = hazard & ~flush.
- Update on each rising clk, by priority:
  - flush=1: load a bubble. valid, regwrite, memread and memwrite go to 0; specifiers go to 0; data and ctrl go to 0. Flush overrides hazard.
  - stall=1: load the same bubble. IF/ID holds externally, so the dependent instruction is re-presented next cycle.
  - otherwise: latch all if_id_* fields. valid=if_id_valid. The write-side controls (regwrite, memread, memwrite) are ANDed with if_id_valid.
- Latency: one cycle from ID inputs to id_ex_* outputs.
- Stall duration is exactly one cycle per load-use pair. After the bubble, id_ex_memread=0, so the hazard clears. Load data then reaches EX via MEM/WB forwarding.
- rd=0 is never a hazard (R0 is not writable).
- rs==rt==load rd still gives one stall, not two.
- Back-to-back loads: a load dependent on a load stalls once, same rule.
- rst asserted mid-stall: outputs clear immediately. stall drops once id_ex_memread=0.
- No internal state besides the pipeline register (and the optional counter below).

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined:
  - Adds output stall_count [15:0], a saturating count of cycles with stall=1 (holds at 0xFFFF).
  - Adds output flush_count [15:0], a saturating count of cycles with flush=1.
  - Both counters clear on rst.
- Undefined: neither port nor counter exists; the rest of the behaviour is identical.

Test Plan:
- Reset: assert rst mid-cycle with nonzero inputs -> all id_ex_* = 0 immediately, stall=0.
- Plain pass-through: rs=1, rt=2, rd=3, rs_data=0x1234, imm=0xFFF0, regwrite=1 -> next cycle id_ex_* match; stall=0 throughout.
- Load-use:
  - Cycle 0: load rd=5 latched into ID/EX.
  - Cycle 1: ID presents add rs=5 -> stall=1 and bubble latched (id_ex_valid=0, regwrite=0).
  - Cycle 2: same add latched, stall=0.
  - With HAZARD_STATS_EN defined, stall_count=1.
- Non-hazards:
  - Load rd=0 followed by rs=0 -> no stall.
  - Load rd=4 followed by an immediate op with rt=4 and uses_rt=0 -> no stall.
- Flush priority: load rd=6 in ID/EX, ID has rs=6, flush=1 -> stall=0, bubble latched, flush_count increments.
- Valid gating: if_id_valid=0 with regwrite=1, memwrite=1 -> id_ex_regwrite=0, id_ex_memwrite=0; a following load-dependency check on that slot does not stall.
